// File: rtl/vga_frame_reader.sv
// Pixel fetch and bounding-box overlay behind the VGA timing controller.
// Doubles a 320x240 RGB444 frame buffer to 640x480 with sync delay-matched to the pixels.
module vga_frame_reader #(
  parameter int          HLINES    = 640,
  parameter int          VLINES    = 480,
  parameter int          SRC_W     = 320,
  parameter int          RD_LAT    = 2,
  parameter int          BOX_W     = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF00
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic        blank_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [16:0] fb_addr,
  input  logic [11:0] fb_data,
  input  logic [10:0] box_x0,
  input  logic [10:0] box_x1,
  input  logic [10:0] box_y0,
  input  logic [10:0] box_y1,
  input  logic        box_valid,
  output logic        box_ready,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);
  localparam logic [10:0] HL = 11'(HLINES);
  localparam logic [10:0] VL = 11'(VLINES);
  localparam logic [16:0] SW = 17'(SRC_W);
  localparam logic [11:0] BW = 12'(BOX_W);

  typedef struct packed {
    logic [10:0] x0, x1, y0, y1;
  } box_t;

  // Everything that must arrive at the output register together with fb_data.
  typedef struct packed {
    logic blank, hs, vs, vis, brd, fs;
  } pipe_t;

  localparam pipe_t PIPE_RST = 6'b111_000;

  box_t        r_shadow, r_active;
  logic        r_shadow_full, r_box_en;
  logic        w_vis, w_commit, w_accept, w_in, w_brd;
  logic [11:0] w_dl, w_dr, w_dt, w_db;
  logic [16:0] w_addr;

  assign w_vis    = (hcounter < HL) && (vcounter < VL);
  assign w_commit = (hcounter == 11'd0) && (vcounter == VL);
  assign w_accept = box_valid && !r_shadow_full;
  assign box_ready = !r_shadow_full;

  assign w_addr = w_vis ? (17'(vcounter[10:1]) * SW + 17'(hcounter[10:1])) : 17'd0;

  // The shadow is only ever loaded while empty and committed while full, so
  // a box offered on the commit cycle waits for the following frame.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_active      <= '0;
      r_shadow_full <= 1'b0;
      r_box_en      <= 1'b0;
    end else if (w_commit && r_shadow_full) begin
      r_active      <= r_shadow;
      r_box_en      <= (r_shadow.x0 <= r_shadow.x1) && (r_shadow.y0 <= r_shadow.y1);
      r_shadow_full <= 1'b0;
    end else if (w_accept) begin
      r_shadow      <= '{x0: box_x0, x1: box_x1, y0: box_y0, y1: box_y1};
      r_shadow_full <= 1'b1;
    end
  end

  assign w_dl = {1'b0, hcounter} - {1'b0, r_active.x0};
  assign w_dr = {1'b0, r_active.x1} - {1'b0, hcounter};
  assign w_dt = {1'b0, vcounter} - {1'b0, r_active.y0};
  assign w_db = {1'b0, r_active.y1} - {1'b0, vcounter};

  assign w_in  = r_box_en &&
                 (hcounter >= r_active.x0) && (hcounter <= r_active.x1) &&
                 (vcounter >= r_active.y0) && (vcounter <= r_active.y1);
  assign w_brd = w_in && ((w_dl < BW) || (w_dr < BW) || (w_dt < BW) || (w_db < BW));

  logic r_vis, r_brd, r_fs;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr <= '0;
      r_vis   <= 1'b0;
      r_brd   <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      fb_addr <= w_addr;
      r_vis   <= w_vis;
      r_brd   <= w_brd;
      r_fs    <= (hcounter == 11'd0) && (vcounter == 11'd0);
    end
  end

  // Sync/blank already lag the counters by one, so they join at the same slot as stage 0.
  pipe_t w_s0, w_tail;
  pipe_t r_pipe [RD_LAT];

  assign w_s0   = {blank_in, hs_in, vs_in, r_vis, r_brd, r_fs};
  assign w_tail = r_pipe[RD_LAT-1];

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= PIPE_RST;
    end else begin
      r_pipe[0] <= w_s0;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  logic [11:0] r_rgb;
  logic        r_hs, r_vs, r_fs_o;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb  <= 12'h000;
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      r_fs_o <= 1'b0;
    end else begin
      r_rgb  <= (w_tail.blank || !w_tail.vis) ? 12'h000 :
                w_tail.brd ? BOX_COLOR : fb_data;
      r_hs   <= w_tail.hs;
      r_vs   <= w_tail.vs;
      r_fs_o <= w_tail.fs;
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign frame_start = r_fs_o;
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: RD_LAT=2 and RD_LAT=4 instances share the counter stream.
module tb_vga_frame_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] hc, vc;
  logic        blank_in = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
  logic [10:0] bx0, bx1, by0, by1;
  logic        bvalid;

  logic [16:0] addr2, addr4;
  logic [11:0] fbd2, fbd4;
  logic        rdy2, rdy4, hs2, hs4, vs2, vs4, fs2, fs4;
  logic [3:0]  r2, g2, b2, r4, g4, b4;

  int n_chk = 0;
  int n_fail = 0;

  vga_frame_reader #(.RD_LAT(2)) u_dut (
    .pixel_clk(clk), .rst_n(rst_n), .hcounter(hc), .vcounter(vc),
    .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
    .fb_addr(addr2), .fb_data(fbd2),
    .box_x0(bx0), .box_x1(bx1), .box_y0(by0), .box_y1(by1),
    .box_valid(bvalid), .box_ready(rdy2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .vga_hs(hs2), .vga_vs(vs2), .frame_start(fs2));

  vga_frame_reader #(.RD_LAT(4)) u_dut4 (
    .pixel_clk(clk), .rst_n(rst_n), .hcounter(hc), .vcounter(vc),
    .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
    .fb_addr(addr4), .fb_data(fbd4),
    .box_x0(bx0), .box_x1(bx1), .box_y0(by0), .box_y1(by1),
    .box_valid(bvalid), .box_ready(rdy4),
    .vga_r(r4), .vga_g(g4), .vga_b(b4),
    .vga_hs(hs4), .vga_vs(vs4), .frame_start(fs4));

  // Timing-controller stand-in: sync/blank registered one cycle after the counters.
  always @(posedge clk) begin
    hs_in    <= !(hc >= 11'd648 && hc < 11'd744);
    vs_in    <= !(vc >= 11'd490 && vc < 11'd492);
    blank_in <= !(hc < 11'd640 && vc < 11'd480);
  end

  // Frame buffer returns addr[11:0] after the instance's read latency.
  logic [11:0] fb2 [2];
  logic [11:0] fb4 [4];
  initial begin
    for (int i = 0; i < 2; i++) fb2[i] = 12'h000;
    for (int i = 0; i < 4; i++) fb4[i] = 12'h000;
  end
  always @(posedge clk) begin
    fb2[0] <= addr2[11:0];
    fb2[1] <= fb2[0];
    fb4[0] <= addr4[11:0];
    for (int i = 1; i < 4; i++) fb4[i] <= fb4[i-1];
  end
  assign fbd2 = fb2[1];
  assign fbd4 = fb4[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v);
    @(negedge clk);
    hc = 11'(h);
    vc = 11'(v);
  endtask

  logic [16:0] p_addr;
  logic        p_rdy;
  logic [11:0] p_rgb2, p_rgb4;
  logic        p_hs2, p_vs2, p_fs2, e_hs2, e_fs2;
  logic        p_hs4, p_vs4, p_fs4, e_hs4, e_fs4;

  // Lead-in pixel, target pixel, then six follow-on pixels; captures each
  // instance's outputs at L-1 (lead-in) and L (target) cycles.
  task automatic probe(input int h, input int v);
    if (h == 0) drive(799, (v == 0) ? 524 : v - 1);
    else        drive(h - 1, v);
    drive(h, v);
    for (int k = 1; k <= 6; k++) begin
      drive(h + k, v);
      case (k)
        1: begin p_addr = addr2; p_rdy = rdy2; end
        3: begin e_hs2 = hs2; e_fs2 = fs2; end
        4: begin p_rgb2 = {r2, g2, b2}; p_hs2 = hs2; p_vs2 = vs2; p_fs2 = fs2; end
        5: begin e_hs4 = hs4; e_fs4 = fs4; end
        6: begin p_rgb4 = {r4, g4, b4}; p_hs4 = hs4; p_vs4 = vs4; p_fs4 = fs4; end
        default: ;
      endcase
    end
  endtask

  task automatic pchk(input string tag, input int h, input int v, input logic [11:0] exp);
    probe(h, v);
    chk({tag, "_rgb2"}, 32'(p_rgb2), 32'(exp));
    chk({tag, "_rgb4"}, 32'(p_rgb4), 32'(exp));
  endtask

  task automatic offer(input int x0, input int x1, input int y0, input int y1);
    @(negedge clk);
    chk("rdy_before_offer", 32'(rdy2), 32'd1);
    bx0 = 11'(x0); bx1 = 11'(x1); by0 = 11'(y0); by1 = 11'(y1);
    bvalid = 1'b1;
    hc = 11'd300; vc = 11'd70;
    @(negedge clk);
    bvalid = 1'b0;
    hc = 11'd301;
    chk("rdy_after_accept", 32'(rdy2), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; hc = '0; vc = '0; bvalid = 1'b0;
    bx0 = '0; bx1 = '0; by0 = '0; by1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr",  32'(addr2), 32'd0);
    chk("rst_rgb",   32'({r2, g2, b2}), 32'h000);
    chk("rst_hs",    32'(hs2), 32'd1);
    chk("rst_vs",    32'(vs2), 32'd1);
    chk("rst_fs",    32'(fs2), 32'd0);
    chk("rst_ready", 32'(rdy2), 32'd1);
    rst_n = 1'b1;

    probe(5, 3);
    chk("addr_5_3", 32'(p_addr), 32'd322);
    chk("rgb2_5_3", 32'(p_rgb2), 32'h142);
    chk("rgb4_5_3", 32'(p_rgb4), 32'h142);
    probe(639, 479);
    chk("addr_max", 32'(p_addr), 32'd76799);
    chk("rgb2_max", 32'(p_rgb2), 32'hBFF);
    chk("rgb4_max", 32'(p_rgb4), 32'hBFF);
    probe(640, 10);
    chk("addr_hblank", 32'(p_addr), 32'd0);
    chk("rgb2_hblank", 32'(p_rgb2), 32'h000);
    chk("rgb4_hblank", 32'(p_rgb4), 32'h000);
    pchk("vblank", 100, 481, 12'h000);

    probe(648, 10);
    chk("hs2_early", 32'(e_hs2), 32'd1);
    chk("hs2_fall",  32'(p_hs2), 32'd0);
    chk("hs4_early", 32'(e_hs4), 32'd1);
    chk("hs4_fall",  32'(p_hs4), 32'd0);
    probe(10, 490);
    chk("vs2_low", 32'(p_vs2), 32'd0);
    chk("vs4_low", 32'(p_vs4), 32'd0);
    probe(10, 489);
    chk("vs2_high", 32'(p_vs2), 32'd1);
    probe(0, 0);
    chk("fs2_early", 32'(e_fs2), 32'd0);
    chk("fs2_pulse", 32'(p_fs2), 32'd1);
    chk("fs4_early", 32'(e_fs4), 32'd0);
    chk("fs4_pulse", 32'(p_fs4), 32'd1);
    probe(1, 0);
    chk("fs2_after", 32'(p_fs2), 32'd0);

    // Box accepted mid-frame only shows after the next commit.
    offer(100, 200, 50, 150);
    pchk("pre_commit", 100, 80, 12'h232);
    probe(0, 480);
    chk("rdy_after_commit", 32'(p_rdy), 32'd1);
    pchk("b_left",    100,  80, 12'hF00);
    pchk("b_right",   200,  60, 12'hF00);
    pchk("b_inner",   102,  80, 12'h233);
    pchk("b_left2",   101,  80, 12'hF00);
    pchk("b_top",     150,  50, 12'hF00);
    pchk("b_top_in",  150,  52, 12'h0CB);
    pchk("b_bot",     150, 149, 12'hF00);
    pchk("b_outside", 201,  80, 12'h264);
    pchk("b_below",   100, 151, 12'hDF2);

    // Inverted box disables the overlay at its commit.
    offer(300, 200, 50, 150);
    pchk("inv_pre", 100, 80, 12'hF00);
    probe(0, 480);
    pchk("inv_left",  100, 80, 12'h232);
    pchk("inv_x0",    300, 50, 12'hFD6);
    pchk("inv_right", 200, 60, 12'h5E4);

    // Box offered on the commit cycle while the shadow is full.
    offer(100, 200, 50, 150);
    @(negedge clk);
    bx0 = 11'd10; bx1 = 11'd20; by0 = 11'd10; by1 = 11'd20;
    bvalid = 1'b1;
    hc = 11'd0; vc = 11'd480;
    @(negedge clk);
    hc = 11'd1;
    chk("sim_rdy_commit", 32'(rdy2), 32'd1);
    @(negedge clk);
    bvalid = 1'b0;
    hc = 11'd2;
    chk("sim_rdy_accept", 32'(rdy2), 32'd0);
    pchk("sim_old_box", 100, 80, 12'hF00);
    pchk("sim_new_wait", 10, 10, 12'h645);
    probe(0, 480);
    pchk("sim_new_box", 10, 10, 12'hF00);
    pchk("sim_new_br",  20, 20, 12'hF00);
    pchk("sim_old_gone", 100, 80, 12'h232);

    // Mid-frame reset with a pending box and an active box.
    offer(400, 500, 100, 200);
    pchk("pre_reset", 319, 240, 12'h69F);
    drive(320, 240);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_rgb",   32'({r2, g2, b2}), 32'h000);
    chk("mrst_hs",    32'(hs2), 32'd1);
    chk("mrst_vs",    32'(vs2), 32'd1);
    chk("mrst_ready", 32'(rdy2), 32'd1);
    chk("mrst_addr",  32'(addr2), 32'd0);
    drive(321, 240);
    drive(322, 240);
    drive(323, 240);
    @(negedge clk);
    rst_n = 1'b1;
    pchk("mrst_active_clr", 10, 10, 12'h645);
    probe(0, 480);
    pchk("mrst_shadow_clr", 450, 100, 12'hF61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
